// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters, the shared UART transmitter and the arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the surroundings: the requesters plus the transmitter's ready flag.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       ack;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic [15:0]              sent_count;
    logic [WIDTH-1:0]         tx_din;
    logic                     tx_enable;
    logic                     tx_ready;

    modport slave (
        input  req, req_data, tx_ready,
        output ack, grant, busy, sent_count, tx_din, tx_enable
    );

    modport master (
        output req, req_data, tx_ready,
        input  ack, grant, busy, sent_count, tx_din, tx_enable
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters.
// The winner's byte is captured when the grant is issued. The arbiter then
// holds the grant until the transmitter has taken the byte and gone idle
// again. All outputs come straight from registers.
//
//  state | meaning
//  IDLE  | no transfer; arbitrate when a request is pending and the UART is ready
//  HOLD  | start pulse issued; waiting for the UART to drop tx_ready
//  DRAIN | UART is shifting the byte out; waiting for tx_ready to return
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input logic               CLK,
    input logic               RST,
    uart_tx_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_t;

    state_t             state_r, state_nxt;
    logic [IDX_W-1:0]   last_r, last_nxt;
    logic [IDX_W-1:0]   owner_r, owner_nxt;
    logic [NUM_REQ-1:0] grant_r, grant_nxt;
    logic [NUM_REQ-1:0] ack_r, ack_nxt;
    logic [WIDTH-1:0]   din_r, din_nxt;
    logic               en_r, en_nxt;
    logic               busy_r, busy_nxt;
    logic [15:0]        sent_count_r, sent_count_nxt;

    logic [WIDTH-1:0]   req_bytes [NUM_REQ];
    logic               found;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand;

    // Split the packed request bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = bus.req_data[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search: start just after the last completed owner and wrap.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_r) + k) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next-state and next-output logic for the transfer sequence.
    always_comb begin
        state_nxt      = state_r;
        last_nxt       = last_r;
        owner_nxt      = owner_r;
        grant_nxt      = grant_r;
        ack_nxt        = '0;
        din_nxt        = din_r;
        en_nxt         = 1'b0;
        sent_count_nxt = sent_count_r;

        case (state_r)
            IDLE: begin
                if (found && bus.tx_ready) begin
                    owner_nxt = winner;
                    din_nxt   = req_bytes[winner];
                    en_nxt    = 1'b1;
                    grant_nxt = NUM_REQ'(1) << winner;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!bus.tx_ready) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.tx_ready) begin
                    ack_nxt        = NUM_REQ'(1) << owner_r;
                    grant_nxt      = '0;
                    last_nxt       = owner_r;
                    sent_count_nxt = sent_count_r + 16'd1;
                    state_nxt      = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers; reset abandons any byte in flight without an ack.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            last_r       <= IDX_W'(NUM_REQ - 1);
            owner_r      <= '0;
            grant_r      <= '0;
            ack_r        <= '0;
            din_r        <= '0;
            en_r         <= 1'b0;
            busy_r       <= 1'b0;
            sent_count_r <= '0;
        end else begin
            state_r      <= state_nxt;
            last_r       <= last_nxt;
            owner_r      <= owner_nxt;
            grant_r      <= grant_nxt;
            ack_r        <= ack_nxt;
            din_r        <= din_nxt;
            en_r         <= en_nxt;
            busy_r       <= busy_nxt;
            sent_count_r <= sent_count_nxt;
        end
    end

    assign bus.ack        = ack_r;
    assign bus.grant      = grant_r;
    assign bus.busy       = busy_r;
    assign bus.sent_count = sent_count_r;
    assign bus.tx_din     = din_r;
    assign bus.tx_enable  = en_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. A small behavioural UART model sits
// behind the arbiter. A table of single transfers checks the round-robin
// order. Hand-written sequences cover tx_ready held low, data changed after
// grant, a late request, reset mid-transfer and counter wrap.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int TX_LEN  = 3;
    localparam int NVEC    = 12;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    // UART model: drops ready the cycle after a start pulse, busy for TX_LEN+1 cycles.
    logic       tx_busy     = 1'b0;
    int         tx_cnt      = 0;
    logic       force_low   = 1'b0;
    logic [7:0] last_byte   = 8'h00;
    int         enable_count = 0;
    int         ack_total   = 0;

    assign bus.tx_ready = !tx_busy && !force_low;

    always @(posedge CLK) begin
        if (RST) begin
            tx_busy <= 1'b0;
            tx_cnt  <= 0;
        end else begin
            if (bus.tx_enable) enable_count <= enable_count + 1;
            if (bus.tx_enable && !tx_busy) begin
                tx_busy   <= 1'b1;
                tx_cnt    <= TX_LEN;
                last_byte <= bus.tx_din;
            end else if (tx_busy) begin
                if (tx_cnt == 0) tx_busy <= 1'b0;
                else             tx_cnt  <= tx_cnt - 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (|bus.ack) ack_total++;
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [7:0] data_v;
    } vec_t;

    vec_t vecs [NVEC];
    int   checks = 0;
    int   errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic wait_enable(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (bus.tx_enable) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL enable_timeout: no tx_enable within 40 cycles");
        end
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (|bus.ack) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ack within 40 cycles");
        end
    endtask

    task automatic do_reset();
        bus.req = '0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        bit ok;
        int ack_before;
        int en_before;

        vecs[0]  = '{4'b1111, 4'b0001, 8'h10};
        vecs[1]  = '{4'b1111, 4'b0010, 8'h11};
        vecs[2]  = '{4'b1111, 4'b0100, 8'h12};
        vecs[3]  = '{4'b1111, 4'b1000, 8'h13};
        vecs[4]  = '{4'b1111, 4'b0001, 8'h10};
        vecs[5]  = '{4'b1010, 4'b0010, 8'h11};
        vecs[6]  = '{4'b1010, 4'b1000, 8'h13};
        vecs[7]  = '{4'b0100, 4'b0100, 8'h12};
        vecs[8]  = '{4'b0100, 4'b0100, 8'h12};
        vecs[9]  = '{4'b0011, 4'b0001, 8'h10};
        vecs[10] = '{4'b1001, 4'b1000, 8'h13};
        vecs[11] = '{4'b1001, 4'b0001, 8'h10};

        bus.req      = '0;
        bus.req_data = 32'h1312_1110;

        // Reset values
        repeat (2) @(negedge CLK);
        check("rst_grant", bus.grant, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_enable", bus.tx_enable, 0);
        check("rst_din", bus.tx_din, 0);
        check("rst_count", bus.sent_count, 0);
        RST = 1'b0;

        // Round-robin table, each next request applied in the ack cycle
        for (int i = 0; i < NVEC; i++) begin
            bus.req = vecs[i].req;
            wait_enable(ok);
            if (ok) begin
                check("vec_grant", bus.grant, vecs[i].grant);
                check("vec_din", bus.tx_din, vecs[i].data_v);
                @(negedge CLK);
                check("vec_pulse", bus.tx_enable, 0);
                wait_ack(ok);
                if (ok) begin
                    check("vec_ack", bus.ack, vecs[i].grant);
                    check("vec_count", bus.sent_count, i + 1);
                    check("vec_ack_nogrant", bus.grant, 0);
                    check("vec_ack_noenable", bus.tx_enable, 0);
                end
            end
        end
        bus.req = '0;

        // Ready held low blocks grant; data change after grant is ignored
        do_reset();
        force_low = 1'b1;
        bus.req = 4'b0001;
        bus.req_data[7:0] = 8'h41;
        repeat (5) @(negedge CLK);
        check("lowrdy_grant", bus.grant, 0);
        check("lowrdy_enable", bus.tx_enable, 0);
        check("lowrdy_busy", bus.busy, 0);
        force_low = 1'b0;
        wait_enable(ok);
        check("a_din", bus.tx_din, 8'h41);
        check("a_grant", bus.grant, 4'b0001);
        check("a_busy", bus.busy, 1);
        bus.req_data[7:0] = 8'h7E;
        @(negedge CLK);
        check("a_pulse", bus.tx_enable, 0);
        check("a_din_hold", bus.tx_din, 8'h41);
        wait_ack(ok);
        check("a_ack", bus.ack, 4'b0001);
        check("a_count", bus.sent_count, 1);
        check("a_sent_byte", last_byte, 8'h41);
        bus.req = '0;
        @(negedge CLK);
        check("a_ack_once", bus.ack, 0);
        check("a_idle_enable", bus.tx_enable, 0);
        check("a_idle_busy", bus.busy, 0);
        bus.req_data[7:0] = 8'h10;

        // Request from 0 arrives while 2 is draining
        do_reset();
        bus.req = 4'b0100;
        wait_enable(ok);
        check("b_grant", bus.grant, 4'b0100);
        for (int c = 0; c < 10 && bus.tx_ready; c++) @(negedge CLK);
        @(negedge CLK);
        bus.req = 4'b0101;
        en_before = enable_count;
        wait_ack(ok);
        check("b_ack", bus.ack, 4'b0100);
        check("b_no_extra_enable", enable_count, en_before);
        bus.req = 4'b0001;
        wait_enable(ok);
        check("b_next_grant", bus.grant, 4'b0001);
        check("b_next_din", bus.tx_din, 8'h10);
        wait_ack(ok);
        check("b_next_ack", bus.ack, 4'b0001);
        bus.req = '0;

        // Reset while requester 1 drains
        do_reset();
        bus.req = 4'b0010;
        wait_enable(ok);
        check("c_grant", bus.grant, 4'b0010);
        for (int c = 0; c < 10 && bus.tx_ready; c++) @(negedge CLK);
        @(negedge CLK);
        ack_before = ack_total;
        RST = 1'b1;
        @(negedge CLK);
        check("c_rst_grant", bus.grant, 0);
        check("c_rst_ack", bus.ack, 0);
        check("c_rst_busy", bus.busy, 0);
        check("c_rst_enable", bus.tx_enable, 0);
        check("c_rst_din", bus.tx_din, 0);
        check("c_rst_count", bus.sent_count, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("c_first_enable", bus.tx_enable, 1);
        check("c_first_grant", bus.grant, 4'b0010);
        check("c_first_din", bus.tx_din, 8'h11);
        check("c_no_aborted_ack", ack_total, ack_before);
        wait_ack(ok);
        check("c_ack", bus.ack, 4'b0010);
        check("c_count", bus.sent_count, 1);
        bus.req = '0;

        // Counter wrap from 0xFFFF
        @(negedge CLK);
        force dut.sent_count_r = 16'hFFFF;
        @(negedge CLK);
        release dut.sent_count_r;
        check("d_preset", bus.sent_count, 16'hFFFF);
        bus.req = 4'b0001;
        wait_enable(ok);
        wait_ack(ok);
        check("d_wrap_ack", bus.ack, 4'b0001);
        check("d_wrap_count", bus.sent_count, 16'h0000);
        bus.req = '0;
        repeat (2) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
